puf_auth_sequencer: RTL

Upstream control stage for the PUF/counter integration block. Accepts challenge requests over a valid/ready handshake and asserts PUF generation until the PUF reports ready. It then captures the 16-bit response, issues a one-cycle counter start, and waits for count completion. Returns the captured response plus a status code, and guards each wait with a timeout and an abort path.

---
 rtl/puf_auth_sequencer_pkg.sv | 28 ++
 rtl/puf_auth_sequencer_if.sv | 36 +++
 rtl/puf_auth_sequencer_seq_timeout_timer.sv | 25 ++
 rtl/puf_auth_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/puf_auth_sequencer_pkg.sv
// Shared types and constants for the PUF authentication sequencer.
// Holds the state encoding, result status codes and default timeouts.
package puf_auth_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_PUF_TO = 2'b01;
    localparam logic [1:0] ST_CNT_TO = 2'b10;
    localparam logic [1:0] ST_ABORT  = 2'b11;

    localparam int DEF_CHAL_W        = 5;
    localparam int DEF_RESP_W        = 16;
    localparam int DEF_PUF_TIMEOUT   = 1024;
    localparam int DEF_COUNT_TIMEOUT = 65600;

    // One extra bit above the larger limit so saturation never aliases a valid count.
    function automatic int timer_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/puf_auth_sequencer_if.sv
// Bundle of request, PUF, counter and result signals around the sequencer.
// Handshakes (req_*, result_*): a transfer happens on a rising clk edge where valid and ready are both 1.
interface puf_auth_sequencer_if #(
    parameter int CHAL_W = 5,
    parameter int RESP_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [CHAL_W-1:0] req_challenge;
    logic              abort;
    logic              puf_generate;
    logic [CHAL_W-1:0] puf_challenge;
    logic              puf_ready;
    logic [RESP_W-1:0] puf_response;
    logic              counter_start;
    logic              count_done;
    logic              result_valid;
    logic              result_ready;
    logic [RESP_W-1:0] result_response;
    logic [1:0]        result_status;
    logic              busy;

    modport slave (
        input  req_valid, req_challenge, abort, puf_ready, puf_response,
               count_done, result_ready,
        output req_ready, puf_generate, puf_challenge, counter_start,
               result_valid, result_response, result_status, busy
    );

    modport master (
        output req_valid, req_challenge, abort, puf_ready, puf_response,
               count_done, result_ready,
        input  req_ready, puf_generate, puf_challenge, counter_start,
               result_valid, result_response, result_status, busy
    );
endinterface

// File: rtl/puf_auth_sequencer_seq_timeout_timer.sv
// Saturating cycle timer guarding the sequencer's wait states.
// expired is high once the count has reached limit-1.
module seq_timeout_timer #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count >= (limit - W'(1)));

endmodule

// File: rtl/puf_auth_sequencer.sv
// Challenge -> PUF generate -> counter start -> wait, returning response and status.
// Every output is a register loaded from the next-state decode.
module puf_auth_sequencer
    import puf_auth_sequencer_pkg::*;
#(
    parameter int CHAL_W        = DEF_CHAL_W,
    parameter int RESP_W        = DEF_RESP_W,
    parameter int PUF_TIMEOUT   = DEF_PUF_TIMEOUT,
    parameter int COUNT_TIMEOUT = DEF_COUNT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    puf_auth_sequencer_if.slave bus,
    output logic [2:0]          dbg_state
);
    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_GEN   = 3'(GEN);
    localparam logic [2:0] S_START = 3'(START);
    localparam logic [2:0] S_WAIT  = 3'(WAIT);
    localparam logic [2:0] S_DONE  = 3'(DONE);
    localparam int         TW      = timer_width(PUF_TIMEOUT, COUNT_TIMEOUT);

    logic [2:0]        state, state_n;
    logic [1:0]        status_n;
    logic              timer_clear, timer_en, timer_expired;
    logic [TW-1:0]     timer_limit;

    logic              req_ready_q, gen_q, start_q, valid_q, busy_q;
    logic [CHAL_W-1:0] chal_q;
    logic [RESP_W-1:0] resp_q;
    logic [1:0]        status_q;

    // abort outranks every completion and timeout; completion outranks timeout.
    always_comb begin
        state_n  = state;
        status_n = status_q;
        case (state)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) state_n = S_GEN;
            end
            S_GEN: begin
                if (bus.abort) begin
                    state_n  = S_DONE;
                    status_n = ST_ABORT;
                end else if (bus.puf_ready) begin
                    state_n  = S_START;
                end else if (timer_expired) begin
                    state_n  = S_DONE;
                    status_n = ST_PUF_TO;
                end
            end
            S_START: begin
                if (bus.abort) begin
                    state_n  = S_DONE;
                    status_n = ST_ABORT;
                end else begin
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_n  = S_DONE;
                    status_n = ST_ABORT;
                end else if (bus.count_done) begin
                    state_n  = S_DONE;
                    status_n = ST_OK;
                end else if (timer_expired) begin
                    state_n  = S_DONE;
                    status_n = ST_CNT_TO;
                end
            end
            S_DONE: begin
                if (bus.result_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Timer restarts on every state change so each wait is measured from entry.
    assign timer_clear = (state_n != state);
    assign timer_en    = (state == S_GEN) || (state == S_WAIT);
    assign timer_limit = (state == S_GEN) ? TW'(PUF_TIMEOUT) : TW'(COUNT_TIMEOUT);

    seq_timeout_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            req_ready_q <= 1'b1;
            gen_q       <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            chal_q      <= '0;
            resp_q      <= '0;
            status_q    <= ST_OK;
        end else begin
            state       <= state_n;
            req_ready_q <= (state_n == S_IDLE);
            gen_q       <= (state_n == S_GEN);
            start_q     <= (state_n == S_START);
            valid_q     <= (state_n == S_DONE);
            busy_q      <= (state_n != S_IDLE);
            status_q    <= status_n;
            // A new request forgets the previous response so an early abort reports 0.
            if ((state == S_IDLE) && (state_n == S_GEN)) begin
                chal_q <= bus.req_challenge;
                resp_q <= '0;
            end
            if ((state == S_GEN) && (state_n == S_START)) begin
                resp_q <= bus.puf_response;
            end
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.puf_generate    = gen_q;
    assign bus.puf_challenge   = chal_q;
    assign bus.counter_start   = start_q;
    assign bus.result_valid    = valid_q;
    assign bus.result_response = resp_q;
    assign bus.result_status   = status_q;
    assign bus.busy            = busy_q;
    assign dbg_state           = state;

endmodule
